// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote, error reporting and valid/ready output
module uart_rx_param #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready_in,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR_S, STOP, BRK_WAIT} state_t;
    state_t state, nxt;

    logic [1:0]           sync;
    logic                 prev;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        t;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] sh;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic                 pbit;
    logic                 perr;
    logic                 ferr_acc;
    logic                 cur, fall, tick, decide, maj, ferr_new, brk, finish, accept, load;

    assign cur      = sync[1];
    assign fall     = prev & ~cur;
    assign tick     = div_cnt == DW'(DIV - 1);
    assign decide   = tick && t == TW'(OVERSAMPLE / 2 + 1);
    assign maj      = (smp[1] & smp[0]) | (smp[1] & cur) | (smp[0] & cur);
    assign ferr_new = ferr_acc | ~maj;
    assign brk      = ~|sh & ~pbit & ferr_new;
    assign accept   = valid & ready_in;
    assign load     = finish & ~brk & (~valid | accept);

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt    = state;
        finish = 1'b0;
        case (state)
            IDLE:     nxt = fall ? START : IDLE;
            START:    nxt = decide ? (maj ? IDLE : DATA) : START;
            DATA:     nxt = (decide && idx == IW'(DATA_BITS - 1)) ? (PARITY != 0 ? PAR_S : STOP) : DATA;
            PAR_S:    nxt = decide ? STOP : PAR_S;
            STOP: begin
                finish = decide && ((STOP_BITS == 1) || stop_idx);
                nxt    = finish ? (brk ? BRK_WAIT : IDLE) : STOP;
            end
            BRK_WAIT: nxt = cur ? IDLE : BRK_WAIT;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            prev       <= 1'b1;
            div_cnt    <= '0;
            t          <= '0;
            smp        <= 2'b11;
            sh         <= '0;
            idx        <= '0;
            stop_idx   <= 1'b0;
            pbit       <= 1'b0;
            perr       <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            sync    <= {sync[0], uart_rx};
            prev    <= cur;
            div_cnt <= ((state == IDLE && fall) || tick) ? '0 : div_cnt + 1'b1;
            // bit phase restarts on the start edge so samples land mid-bit
            if (state == IDLE && fall) t <= '0;
            else if (tick)             t <= (t == TW'(OVERSAMPLE - 1)) ? '0 : t + 1'b1;
            if (tick && (t == TW'(OVERSAMPLE / 2 - 1) || t == TW'(OVERSAMPLE / 2))) smp <= {smp[0], cur};
            if (state == IDLE) begin
                idx      <= '0;
                stop_idx <= 1'b0;
                pbit     <= 1'b0;
                perr     <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (decide && state == DATA) begin
                sh[idx] <= maj;
                idx     <= idx + 1'b1;
            end
            if (decide && state == PAR_S) begin
                pbit <= maj;
                perr <= (PARITY == 1) ? ~(^sh ^ maj) : (^sh ^ maj);
            end
            if (decide && state == STOP) begin
                ferr_acc <= ferr_new;
                stop_idx <= 1'b1;
            end
            break_det <= finish & brk;
            overrun   <= finish & ~brk & valid & ~accept;
            valid     <= load | (valid & ~ready_in);
            if (load) begin
                data       <= sh;
                frame_err  <= ferr_new;
                parity_err <= perr;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed vectors for an 8N1 and an 8E1 receiver at 160 clocks per bit
module tb_uart_rx_param;
    logic clk = 1'b0, rst = 1'b1, ready_in = 1'b0, rx8 = 1'b1, rxp = 1'b1;
    logic [7:0] d8, dp;
    logic v8, fe8, pe8, ov8, bk8, vp, fep, pep, ovp, bkp;
    bit sel = 1'b0;
    int n_cmp = 0, n_fail = 0, ov_cnt = 0, bk_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u8 (
        .clk(clk), .rst(rst), .uart_rx(rx8), .data(d8), .valid(v8), .ready_in(ready_in),
        .frame_err(fe8), .parity_err(pe8), .overrun(ov8), .break_det(bk8));

    uart_rx_param #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .OVERSAMPLE(16)) up (
        .clk(clk), .rst(rst), .uart_rx(rxp), .data(dp), .valid(vp), .ready_in(ready_in),
        .frame_err(fep), .parity_err(pep), .overrun(ovp), .break_det(bkp));

    always @(negedge clk) begin
        if (ov8) ov_cnt++;
        if (bk8) bk_cnt++;
    end

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic [7:0] ed;
        logic       ef;
        logic       ep;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic send(input bit s, input logic [7:0] d, input logic pb, input logic sb);
        logic [11:0] b;
        int n;
        b = s ? {1'b1, sb, pb, d, 1'b0} : {2'b11, sb, d, 1'b0};
        n = s ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            if (s) rxp = b[i]; else rx8 = b[i];
            repeat (160) @(posedge clk);
        end
        if (s) rxp = 1'b1; else rx8 = 1'b1;
    endtask

    task automatic wait_valid(input bit s);
        for (int i = 0; i < 400 && !(s ? vp : v8); i++) @(negedge clk);
    endtask

    task automatic accept(input bit s);
        @(posedge clk);
        #1 ready_in = 1'b1;
        @(posedge clk);
        #1 ready_in = 1'b0;
        chk("valid_clear", s ? vp : v8, 1'b0);
        repeat (40) @(posedge clk);
    endtask

    task automatic rx_check(input bit s, input logic [7:0] d, input logic pb, input logic sb,
                            input logic [7:0] ed, input logic ef, input logic ep);
        send(s, d, pb, sb);
        wait_valid(s);
        @(negedge clk);
        chk("valid", s ? vp : v8, 1'b1);
        chk("data", s ? dp : d8, ed);
        chk("frame_err", s ? fep : fe8, ef);
        chk("parity_err", s ? pep : pe8, ep);
        accept(s);
    endtask

    initial begin
        int base, bad;
        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        tbl[2] = '{1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
        tbl[3] = '{1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[4] = '{0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        tbl[5] = '{1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", v8, 1'b0);
        chk("rst_data", d8, 8'h00);
        chk("rst_flags", {fe8, pe8, ov8, bk8, vp, fep, pep}, 7'b0);
        repeat (20) @(posedge clk);

        for (int i = 0; i < 6; i++)
            rx_check(tbl[i].sel, tbl[i].d, tbl[i].pb, tbl[i].sb, tbl[i].ed, tbl[i].ef, tbl[i].ep);

        // held word must not move while the consumer stalls
        send(0, 8'hA5, 1'b0, 1'b1);
        wait_valid(0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!v8 || d8 !== 8'hA5) bad++;
        end
        chk("hold_1000", bad, 0);
        accept(0);

        base = bk_cnt;
        rx8 = 1'b0;
        repeat (50) @(posedge clk);
        rx8 = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_valid", v8, 1'b0);
        chk("glitch_break", bk_cnt - base, 0);
        rx_check(0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);

        base = bk_cnt;
        rx8 = 1'b0;
        repeat (12 * 160) @(posedge clk);
        rx8 = 1'b1;
        repeat (200) @(negedge clk);
        chk("break_pulses", bk_cnt - base, 1);
        chk("break_valid", v8, 1'b0);
        rx_check(0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);

        base = ov_cnt;
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        chk("ovr_pulses", ov_cnt - base, 1);
        chk("ovr_valid", v8, 1'b1);
        chk("ovr_data", d8, 8'h11);
        accept(0);

        base = ov_cnt;
        fork
            send(0, 8'h11, 1'b0, 1'b1);
            begin
                repeat (720) @(posedge clk);
                #1 rst = 1'b1;
                repeat (800) @(negedge clk);
                chk("mid_rst_outs", {v8, d8, fe8, pe8, ov8, bk8}, 13'b0);
                #1 rst = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        chk("post_rst_valid", v8, 1'b0);
        rx_check(0, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        chk("post_rst_ovr", ov_cnt - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
